// File: rtl/itch_msg_dispatcher.sv
// Frames a 64-bit beat stream of length-prefixed ITCH messages and drives per-type parser starts.
// All eight bytes of a valid beat are walked in order through the header/body FSM in one cycle.
module itch_msg_dispatcher #(
  parameter int unsigned MIN_LEN = 9,
  parameter int unsigned MAX_LEN = 64,
  parameter logic [7:0]  TYPE_A  = 8'h41,
  parameter logic [7:0]  TYPE_F  = 8'h46,
  parameter logic [7:0]  TYPE_E  = 8'h45,
  parameter logic [7:0]  TYPE_D  = 8'h44
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_in,
  input  logic        data_valid,
  output logic [63:0] data_out,
  output logic [5:0]  tracker_out,
  output logic        msg_start,
  output logic [7:0]  msg_type,
  output logic [15:0] body_len,
  output logic        start_add_order_no_mpid,
  output logic        start_add_order_mpid,
  output logic        start_order_executed,
  output logic        start_order_delete,
  output logic        msg_end,
  output logic [15:0] unknown_count,
  output logic [31:0] msg_count,
  output logic        err
);

  localparam logic [2:0] StHdr0 = 3'd0;
  localparam logic [2:0] StHdr1 = 3'd1;
  localparam logic [2:0] StHdr2 = 3'd2;
  localparam logic [2:0] StBody = 3'd3;
  localparam logic [2:0] StErr  = 3'd4;

  localparam logic [15:0] MinLen = 16'(MIN_LEN);
  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  logic [2:0]  st_q, st_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  type_q, type_d;
  logic [15:0] body_len_q, body_len_d;
  logic        pend_q, pend_d;
  logic [63:0] data_q, data_d;
  logic [5:0]  tracker_q, tracker_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic [3:0]  lvl_q, lvl_d;
  logic [15:0] unk_q, unk_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [7:0]  byte_v;
  logic        hdr_seen;
  logic        lvl_any;
  logic [7:0]  lvl_type;
  logic        known;

  always_comb begin
    st_d       = st_q;
    len_d      = len_q;
    rem_d      = rem_q;
    type_d     = type_q;
    body_len_d = body_len_q;
    pend_d     = pend_q;
    err_d      = err_q;
    start_d    = 1'b0;
    tracker_d  = '0;
    end_d      = 1'b0;
    hdr_seen   = 1'b0;
    lvl_any    = 1'b0;
    lvl_type   = type_q;
    byte_v     = '0;
    data_d     = data_valid ? data_in : '0;
    if (data_valid) begin
      // Type byte landed in byte 7 of the previous beat: the body starts at byte 0 here.
      if (pend_q) begin
        start_d = 1'b1;
        pend_d  = 1'b0;
      end
      for (int k = 0; k < 8; k++) begin
        byte_v = data_in[8*k +: 8];
        case (st_d)
          StHdr0: begin
            len_d[15:8] = byte_v;
            st_d        = StHdr1;
          end
          StHdr1: begin
            len_d[7:0] = byte_v;
            if (len_d < MinLen || len_d > MaxLen) begin
              err_d = 1'b1;
              st_d  = StErr;
            end else begin
              st_d = StHdr2;
            end
          end
          StHdr2: begin
            type_d     = byte_v;
            rem_d      = len_d - 16'd1;
            body_len_d = len_d - 16'd1;
            hdr_seen   = 1'b1;
            st_d       = StBody;
            if (k < 7) begin
              start_d   = 1'b1;
              tracker_d = 6'((k + 1) * 8);
            end else begin
              pend_d = 1'b1;
            end
          end
          StBody: begin
            rem_d    = rem_d - 16'd1;
            lvl_any  = 1'b1;
            lvl_type = type_d;
            if (rem_d == 16'd0) begin
              end_d = 1'b1;
              st_d  = StHdr0;
            end
          end
          default: ;
        endcase
      end
    end

    known = (type_d == TYPE_A) || (type_d == TYPE_F) || (type_d == TYPE_E) || (type_d == TYPE_D);
    cnt_d = cnt_q + {31'd0, hdr_seen};
    unk_d = unk_q;
    if (hdr_seen && !known && unk_q != 16'hFFFF) unk_d = unk_q + 16'd1;

    // Level follows the message owning the latest body byte, so old drops as new rises.
    lvl_d[0] = lvl_any && (lvl_type == TYPE_A);
    lvl_d[1] = lvl_any && (lvl_type == TYPE_F);
    lvl_d[2] = lvl_any && (lvl_type == TYPE_E);
    lvl_d[3] = lvl_any && (lvl_type == TYPE_D);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= StHdr0;
      len_q      <= '0;
      rem_q      <= '0;
      type_q     <= '0;
      body_len_q <= '0;
      pend_q     <= 1'b0;
      data_q     <= '0;
      tracker_q  <= '0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      lvl_q      <= '0;
      unk_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      st_q       <= st_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      type_q     <= type_d;
      body_len_q <= body_len_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      tracker_q  <= tracker_d;
      start_q    <= start_d;
      end_q      <= end_d;
      lvl_q      <= lvl_d;
      unk_q      <= unk_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign data_out                = data_q;
  assign tracker_out             = tracker_q;
  assign msg_start               = start_q;
  assign msg_type                = type_q;
  assign body_len                = body_len_q;
  assign start_add_order_no_mpid = lvl_q[0];
  assign start_add_order_mpid    = lvl_q[1];
  assign start_order_executed    = lvl_q[2];
  assign start_order_delete      = lvl_q[3];
  assign msg_end                 = end_q;
  assign unknown_count           = unk_q;
  assign msg_count               = cnt_q;
  assign err                     = err_q;

endmodule

// File: tb/tb_itch_msg_dispatcher.sv
// Directed bench for itch_msg_dispatcher: byte-queue stimulus, hand-derived per-beat expectations.
module tb_itch_msg_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic [63:0] data_out;
  logic [5:0]  tracker_out;
  logic        msg_start;
  logic [7:0]  msg_type;
  logic [15:0] body_len;
  logic        s_a, s_f, s_e, s_d;
  logic        msg_end;
  logic [15:0] unknown_count;
  logic [31:0] msg_count;
  logic        err;

  localparam logic [3:0] L0 = 4'b0000;
  localparam logic [3:0] LA = 4'b0001;
  localparam logic [3:0] LE = 4'b0100;
  localparam logic [3:0] LD = 4'b1000;

  int vec  = 0;
  int miss = 0;
  logic [7:0]  q[$];
  logic [63:0] cur;
  logic [3:0]  lv;

  assign lv = {s_d, s_e, s_f, s_a};

  itch_msg_dispatcher dut (
    .clk                     (clk),
    .rst                     (rst),
    .data_in                 (data_in),
    .data_valid              (data_valid),
    .data_out                (data_out),
    .tracker_out             (tracker_out),
    .msg_start               (msg_start),
    .msg_type                (msg_type),
    .body_len                (body_len),
    .start_add_order_no_mpid (s_a),
    .start_add_order_mpid    (s_f),
    .start_order_executed    (s_e),
    .start_order_delete      (s_d),
    .msg_end                 (msg_end),
    .unknown_count           (unknown_count),
    .msg_count               (msg_count),
    .err                     (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic st, input logic [5:0] trk,
                          input logic en, input logic [3:0] lvl);
    chk({tag, ".start"}, 64'(msg_start), 64'(st));
    chk({tag, ".trk"}, 64'(tracker_out), 64'(trk));
    chk({tag, ".end"}, 64'(msg_end), 64'(en));
    chk({tag, ".lvl"}, 64'(lv), 64'(lvl));
  endtask

  task automatic add_msg(input logic [15:0] len, input logic [7:0] typ);
    q.push_back(len[15:8]);
    q.push_back(len[7:0]);
    q.push_back(typ);
    for (int i = 1; i < int'(len); i++) q.push_back(8'(i) ^ typ);
  endtask

  task automatic beat();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = (q.size() > 0) ? q.pop_front() : 8'h00;
    data_in    = d;
    cur        = d;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_in    = {$urandom, $urandom};
    data_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst.data", data_out, 64'd0);
    chk("rst.cnt", 64'(msg_count), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk_beat("rst", 1'b0, 6'd0, 1'b0, L0);

    // 1: aligned 'A' len=37
    add_msg(16'd37, 8'h41);
    beat();
    chk_beat("t1.b0", 1'b1, 6'd24, 1'b0, LA);
    chk("t1.data", data_out, cur);
    chk("t1.type", 64'(msg_type), 64'h41);
    chk("t1.blen", 64'(body_len), 64'd36);
    chk("t1.cnt", 64'(msg_count), 64'd1);
    beat(); chk_beat("t1.b1", 1'b0, 6'd0, 1'b0, LA);
    beat(); chk_beat("t1.b2", 1'b0, 6'd0, 1'b0, LA);
    beat(); chk_beat("t1.b3", 1'b0, 6'd0, 1'b0, LA);
    beat(); chk_beat("t1.b4", 1'b1 & 1'b0, 6'd0, 1'b1, LA);
    idle(); chk_beat("t1.idle", 1'b0, 6'd0, 1'b0, L0);

    // 2: 'E' len=11 ends at byte 4, 'D' header at bytes 5..7
    do_reset();
    add_msg(16'd11, 8'h45);
    add_msg(16'd18, 8'h44);
    beat(); chk_beat("t2.b0", 1'b1, 6'd24, 1'b0, LE);
    beat(); chk_beat("t2.b1", 1'b0, 6'd0, 1'b1, LE);
    chk("t2.type", 64'(msg_type), 64'h44);
    chk("t2.cnt", 64'(msg_count), 64'd2);
    beat(); chk_beat("t2.b2", 1'b1, 6'd0, 1'b0, LD);
    beat(); chk_beat("t2.b3", 1'b0, 6'd0, 1'b0, LD);
    beat(); chk_beat("t2.b4", 1'b0, 6'd0, 1'b1, LD);

    // 3: 'D' len=18 then 'A' len=37, end and next start share beat 2
    do_reset();
    add_msg(16'd18, 8'h44);
    add_msg(16'd37, 8'h41);
    beat(); chk_beat("t3.b0", 1'b1, 6'd24, 1'b0, LD);
    beat(); chk_beat("t3.b1", 1'b0, 6'd0, 1'b0, LD);
    beat(); chk_beat("t3.b2", 1'b1, 6'd56, 1'b1, LA);
    chk("t3.cnt", 64'(msg_count), 64'd2);
    chk("t3.type", 64'(msg_type), 64'h41);
    for (int b = 3; b < 7; b++) begin
      beat(); chk_beat("t3.mid", 1'b0, 6'd0, 1'b0, LA);
    end
    beat(); chk_beat("t3.b7", 1'b0, 6'd0, 1'b1, LA);

    // 4: stall 3 cycles mid-body
    do_reset();
    add_msg(16'd37, 8'h41);
    beat(); chk_beat("t4.b0", 1'b1, 6'd24, 1'b0, LA);
    beat(); chk_beat("t4.b1", 1'b0, 6'd0, 1'b0, LA);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk_beat("t4.idle", 1'b0, 6'd0, 1'b0, L0);
      chk("t4.idata", data_out, 64'd0);
      chk("t4.icnt", 64'(msg_count), 64'd1);
    end
    beat(); chk_beat("t4.b2", 1'b0, 6'd0, 1'b0, LA);
    beat(); chk_beat("t4.b3", 1'b0, 6'd0, 1'b0, LA);
    beat(); chk_beat("t4.b4", 1'b0, 6'd0, 1'b1, LA);

    // 5: illegal len=5, then reset mid-message
    do_reset();
    add_msg(16'd5, 8'h41);
    beat();
    chk("t5.err", 64'(err), 64'd1);
    add_msg(16'd37, 8'h41);
    beat(); chk_beat("t5.e1", 1'b0, 6'd0, 1'b0, L0);
    beat(); chk_beat("t5.e2", 1'b0, 6'd0, 1'b0, L0);
    chk("t5.cnt", 64'(msg_count), 64'd0);
    chk("t5.err2", 64'(err), 64'd1);
    do_reset();
    add_msg(16'd37, 8'h41);
    beat();
    beat();
    rst = 1'b0;
    #1;
    chk_beat("t5.rst", 1'b0, 6'd0, 1'b0, L0);
    chk("t5.rdata", data_out, 64'd0);
    chk("t5.rcnt", 64'(msg_count), 64'd0);
    chk("t5.rtype", 64'(msg_type), 64'd0);
    q.delete();
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    add_msg(16'd37, 8'h41);
    beat(); chk_beat("t5.re", 1'b1, 6'd24, 1'b0, LA);
    chk("t5.recnt", 64'(msg_count), 64'd1);

    // 6: unknown 8'h5A len=12, then 'E' len=11 straddling beats
    do_reset();
    add_msg(16'd12, 8'h5A);
    add_msg(16'd11, 8'h45);
    beat();
    chk("t6.lvl0", 64'(lv), 64'(L0));
    chk("t6.unk", 64'(unknown_count), 64'd1);
    beat();
    chk("t6.end", 64'(msg_end), 64'd1);
    chk("t6.lvl1", 64'(lv), 64'(L0));
    beat(); chk_beat("t6.b2", 1'b1, 6'd8, 1'b0, LE);
    chk("t6.type", 64'(msg_type), 64'h45);
    chk("t6.cnt", 64'(msg_count), 64'd2);
    chk("t6.unk2", 64'(unknown_count), 64'd1);
    beat(); chk_beat("t6.b3", 1'b0, 6'd0, 1'b1, LE);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
